// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared LCD widths, capture FSM states and panel timing constants
package lcd_pkg;

    localparam int X_W   = 10;
    localparam int Y_W   = 9;
    localparam int RGB_W = 24;

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_MEASURE = 2'd1,
        ST_LOCKED  = 2'd2
    } cap_state_t;

    // Small simulation timing: 64x32 active inside 69x35 total
    localparam int SIM_H_ACTIVE = 64;
    localparam int SIM_H_BLANK  = 5;
    localparam int SIM_H_TOTAL  = 69;
    localparam int SIM_V_ACTIVE = 32;
    localparam int SIM_V_BLANK  = 3;
    localparam int SIM_V_TOTAL  = 35;
    localparam int SIM_CLK_DIV  = 5;

    // 480x272 panel timing
    localparam int P480_H_ACTIVE = 480;
    localparam int P480_H_BLANK  = 45;
    localparam int P480_H_TOTAL  = 525;
    localparam int P480_V_ACTIVE = 272;
    localparam int P480_V_BLANK  = 16;
    localparam int P480_V_TOTAL  = 288;

endpackage

// File: rtl/lcd_sync_edge.sv
// rtl/lcd_sync_edge.sv - 2-flop synchronizer with a third flop for rise/fall detection
module lcd_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [2:0] sync_q;
    logic [2:0] sync_d;

    // shift the asynchronous input through the three-stage chain
    always_comb begin
        sync_d = {sync_q[1:0], d};
    end

    // synchronizer and edge-history register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q    = sync_q[1];
    assign rise = sync_q[1] & ~sync_q[2];
    assign fall = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/lcd_rgb_capture.sv
// rtl/lcd_rgb_capture.sv - parallel RGB LCD receiver with geometry measurement and lock tracking
module lcd_rgb_capture
    import lcd_pkg::*;
#(
    parameter int MAX_W = 1023,
    parameter int MAX_H = 511
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 lcd_dclk,
    input  logic                 lcd_de,
    input  logic                 lcd_hsync,
    input  logic                 lcd_vsync,
    input  logic [7:0]           lcd_red,
    input  logic [7:0]           lcd_green,
    input  logic [7:0]           lcd_blue,
    output logic                 pix_valid,
    output logic [RGB_W-1:0]     pix_data,
    output logic [X_W-1:0]       pix_x,
    output logic [Y_W-1:0]       pix_y,
    output logic                 sof,
    output logic                 eol,
    output logic [X_W-1:0]       frame_width,
    output logic [Y_W-1:0]       frame_height,
    output logic [11:0]          frame_count,
    output logic                 locked,
    output logic                 timing_err
);

    localparam int BUS_W = RGB_W + 2;
    localparam logic [X_W-1:0] X_MAX = X_W'(MAX_W);
    localparam logic [Y_W-1:0] Y_MAX = Y_W'(MAX_H);

    // hsync carries no information in DE mode
    logic hsync_unused;
    assign hsync_unused = lcd_hsync;

    logic dclk_q_unused, dclk_fall_unused, dclk_rise;

    lcd_sync_edge u_dclk_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (lcd_dclk),
        .q     (dclk_q_unused),
        .rise  (dclk_rise),
        .fall  (dclk_fall_unused)
    );

    logic [BUS_W-1:0] bus_s1_q, bus_s1_d, bus_s2_q, bus_s2_d;

    // data lines get the same two-stage depth as dclk so they line up with the rise
    always_comb begin
        bus_s1_d = {lcd_de, lcd_vsync, lcd_red, lcd_green, lcd_blue};
        bus_s2_d = bus_s1_q;
    end

    cap_state_t       state_q, state_d;
    logic             primed_q, primed_d;
    logic             de_prev_q, de_prev_d, vs_prev_q, vs_prev_d;
    logic [X_W-1:0]   x_q, x_d, ref_w_q, ref_w_d;
    logic [Y_W-1:0]   y_q, y_d;
    logic             ref_valid_q, ref_valid_d, bad_q, bad_d;
    logic             pix_valid_q, pix_valid_d, sof_q, sof_d, eol_q, eol_d;
    logic [RGB_W-1:0] pix_data_q, pix_data_d;
    logic [X_W-1:0]   pix_x_q, pix_x_d, frame_width_q, frame_width_d;
    logic [Y_W-1:0]   pix_y_q, pix_y_d, frame_height_q, frame_height_d;
    logic [11:0]      frame_count_q, frame_count_d;
    logic             locked_q, locked_d, timing_err_q, timing_err_d;

    logic             ev_en, de_s, vs_s, vs_rise, de_rise, de_fall;
    logic             frame_ok, frame_mismatch;
    logic [RGB_W-1:0] rgb_s;
    logic [X_W-1:0]   line_w, x_cur;
    logic [Y_W-1:0]   y_cur;

    // the first sample after reset only seeds the edge history
    assign ev_en   = dclk_rise & primed_q;
    assign de_s    = bus_s2_q[BUS_W-1];
    assign vs_s    = bus_s2_q[BUS_W-2];
    assign rgb_s   = bus_s2_q[RGB_W-1:0];
    assign vs_rise = ev_en & vs_s & ~vs_prev_q;
    assign de_rise = ev_en & de_s & ~de_prev_q;
    assign de_fall = ev_en & ~de_s & de_prev_q;

    // frame-end judgement always uses the counters as they stood before this sample
    assign line_w         = ref_valid_q ? ref_w_q : '0;
    assign frame_ok       = !bad_q && (line_w != '0) && (y_q != '0);
    assign frame_mismatch = bad_q || (line_w != frame_width_q) || (y_q != frame_height_q);

    // capture FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_SEARCH;
        end else begin
            state_q <= state_d;
        end
    end

    // capture FSM transitions, all taken at a frame end
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_SEARCH:  if (vs_rise) state_d = ST_MEASURE;
            ST_MEASURE: if (vs_rise && frame_ok) state_d = ST_LOCKED;
            ST_LOCKED:  if (vs_rise && frame_mismatch) state_d = ST_MEASURE;
            default:    state_d = ST_SEARCH;
        endcase
    end

    // counters, geometry checks, frame-end results and pixel output
    always_comb begin
        primed_d       = primed_q | dclk_rise;
        de_prev_d      = dclk_rise ? de_s : de_prev_q;
        vs_prev_d      = dclk_rise ? vs_s : vs_prev_q;
        x_d            = x_q;
        y_d            = y_q;
        ref_w_d        = ref_w_q;
        ref_valid_d    = ref_valid_q;
        bad_d          = bad_q;
        pix_valid_d    = 1'b0;
        pix_data_d     = pix_data_q;
        pix_x_d        = pix_x_q;
        pix_y_d        = pix_y_q;
        sof_d          = 1'b0;
        eol_d          = 1'b0;
        frame_width_d  = frame_width_q;
        frame_height_d = frame_height_q;
        frame_count_d  = frame_count_q;
        locked_d       = locked_q;
        timing_err_d   = 1'b0;
        y_cur          = vs_rise ? '0 : y_q;
        x_cur          = de_rise ? '0 : x_q;

        if (de_fall) begin
            if (!ref_valid_q) begin
                ref_w_d     = x_q;
                ref_valid_d = 1'b1;
            end else if (x_q != ref_w_q) begin
                bad_d = 1'b1;
            end
            if (y_q == Y_MAX) begin
                bad_d = 1'b1;
            end else begin
                y_d = y_q + 1'b1;
            end
            eol_d = (state_q != ST_SEARCH);
        end

        if (vs_rise) begin
            if (state_q == ST_MEASURE) begin
                frame_width_d  = line_w;
                frame_height_d = y_q;
                locked_d       = frame_ok;
            end else if (state_q == ST_LOCKED) begin
                if (frame_mismatch) begin
                    timing_err_d = 1'b1;
                    locked_d     = 1'b0;
                end else begin
                    frame_count_d = frame_count_q + 12'd1;
                end
            end
            x_d         = '0;
            y_d         = '0;
            ref_w_d     = '0;
            ref_valid_d = 1'b0;
            bad_d       = 1'b0;
        end

        // a line starting with y already saturated means vsync went missing
        if (de_rise) begin
            x_d = '0;
            if (y_cur == Y_MAX) bad_d = 1'b1;
        end

        if (ev_en && de_s && (state_d != ST_SEARCH)) begin
            pix_valid_d = 1'b1;
            pix_data_d  = rgb_s;
            pix_x_d     = x_cur;
            pix_y_d     = y_cur;
            sof_d       = (x_cur == '0) && (y_cur == '0);
            if (x_cur == X_MAX) begin
                bad_d = 1'b1;
            end else begin
                x_d = x_cur + 1'b1;
            end
        end
    end

    // datapath and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus_s1_q       <= '0;
            bus_s2_q       <= '0;
            primed_q       <= 1'b0;
            de_prev_q      <= 1'b0;
            vs_prev_q      <= 1'b0;
            x_q            <= '0;
            y_q            <= '0;
            ref_w_q        <= '0;
            ref_valid_q    <= 1'b0;
            bad_q          <= 1'b0;
            pix_valid_q    <= 1'b0;
            pix_data_q     <= '0;
            pix_x_q        <= '0;
            pix_y_q        <= '0;
            sof_q          <= 1'b0;
            eol_q          <= 1'b0;
            frame_width_q  <= '0;
            frame_height_q <= '0;
            frame_count_q  <= '0;
            locked_q       <= 1'b0;
            timing_err_q   <= 1'b0;
        end else begin
            bus_s1_q       <= bus_s1_d;
            bus_s2_q       <= bus_s2_d;
            primed_q       <= primed_d;
            de_prev_q      <= de_prev_d;
            vs_prev_q      <= vs_prev_d;
            x_q            <= x_d;
            y_q            <= y_d;
            ref_w_q        <= ref_w_d;
            ref_valid_q    <= ref_valid_d;
            bad_q          <= bad_d;
            pix_valid_q    <= pix_valid_d;
            pix_data_q     <= pix_data_d;
            pix_x_q        <= pix_x_d;
            pix_y_q        <= pix_y_d;
            sof_q          <= sof_d;
            eol_q          <= eol_d;
            frame_width_q  <= frame_width_d;
            frame_height_q <= frame_height_d;
            frame_count_q  <= frame_count_d;
            locked_q       <= locked_d;
            timing_err_q   <= timing_err_d;
        end
    end

    assign pix_valid    = pix_valid_q;
    assign pix_data     = pix_data_q;
    assign pix_x        = pix_x_q;
    assign pix_y        = pix_y_q;
    assign sof          = sof_q;
    assign eol          = eol_q;
    assign frame_width  = frame_width_q;
    assign frame_height = frame_height_q;
    assign frame_count  = frame_count_q;
    assign locked       = locked_q;
    assign timing_err   = timing_err_q;

endmodule

// File: tb/tb_lcd_rgb_capture.sv
// tb/tb_lcd_rgb_capture.sv - scoreboard bench for lcd_rgb_capture driven by an in-bench RGB source
module tb_lcd_rgb_capture;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        lcd_dclk, lcd_de, lcd_hsync, lcd_vsync;
    logic [7:0]  lcd_red, lcd_green, lcd_blue;
    logic        pix_valid, sof, eol, locked, timing_err;
    logic [23:0] pix_data;
    logic [9:0]  pix_x, frame_width;
    logic [8:0]  pix_y, frame_height;
    logic [11:0] frame_count;

    always #5 clk = ~clk;

    lcd_rgb_capture dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .lcd_dclk     (lcd_dclk),
        .lcd_de       (lcd_de),
        .lcd_hsync    (lcd_hsync),
        .lcd_vsync    (lcd_vsync),
        .lcd_red      (lcd_red),
        .lcd_green    (lcd_green),
        .lcd_blue     (lcd_blue),
        .pix_valid    (pix_valid),
        .pix_data     (pix_data),
        .pix_x        (pix_x),
        .pix_y        (pix_y),
        .sof          (sof),
        .eol          (eol),
        .frame_width  (frame_width),
        .frame_height (frame_height),
        .frame_count  (frame_count),
        .locked       (locked),
        .timing_err   (timing_err)
    );

    typedef struct {
        logic [23:0] data;
        int          x;
        int          y;
        logic        sof;
        longint      cyc;
    } exp_t;

    exp_t   sb[$];
    exp_t   mon_e;
    int     n_checks = 0;
    int     n_fail   = 0;
    longint cyc      = 0;
    bit     exp_active = 1'b0;
    int     pix_cnt = 0, sof_cnt = 0, eol_cnt = 0, terr_cnt = 0;
    int     last_x = -1, last_y = -1;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [23:0] pat(input int x, input int y);
        int r, g, b;
        r = x * 5 + 1;
        g = y * 3 + x;
        b = x ^ (y * 4);
        return {r[7:0], g[7:0], b[7:0]};
    endfunction

    // monitor: pop and compare on every strobe, tally event pulses
    always @(negedge clk) begin
        if (pix_valid === 1'b1) begin
            pix_cnt++;
            if (sof === 1'b1) sof_cnt++;
            last_x = int'(pix_x);
            last_y = int'(pix_y);
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_pixel actual x=%0d y=%0d data=%h, required no pixel", pix_x, pix_y, pix_data);
            end else begin
                mon_e = sb.pop_front();
                if ({pix_data, pix_x, pix_y, sof} !== {mon_e.data, 10'(mon_e.x), 9'(mon_e.y), mon_e.sof}
                    || (cyc - mon_e.cyc) != 3) begin
                    n_fail++;
                    $display("FAIL pixel actual data=%h x=%0d y=%0d sof=%b lat=%0d, required data=%h x=%0d y=%0d sof=%b lat=3",
                             pix_data, pix_x, pix_y, sof, cyc - mon_e.cyc,
                             mon_e.data, mon_e.x, mon_e.y, mon_e.sof);
                end
            end
        end
        if (eol === 1'b1) eol_cnt++;
        if (timing_err === 1'b1) terr_cnt++;
    end

    task automatic check(input string name, input longint act, input longint req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // one dclk period of 6 clk; data changes with the falling edge
    task automatic dclk_cycle(input logic de, input logic vs, input int x, input int y);
        logic [23:0] d;
        exp_t e;
        d = de ? pat(x, y) : 24'h0;
        lcd_dclk  = 1'b0;
        lcd_de    = de;
        lcd_vsync = vs;
        lcd_hsync = ~de;
        {lcd_red, lcd_green, lcd_blue} = d;
        repeat (3) @(negedge clk);
        lcd_dclk = 1'b1;
        if (de && exp_active) begin
            e.data = d;
            e.x    = x;
            e.y    = (y > 511) ? 511 : y;
            e.sof  = (x == 0) && (y == 0);
            e.cyc  = cyc;
            sb.push_back(e);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) dclk_cycle(1'b0, 1'b0, 0, 0);
    endtask

    task automatic vblank(input int lines, input int len);
        exp_active = 1'b1;
        for (int l = 0; l < lines; l++)
            for (int c = 0; c < len; c++)
                dclk_cycle(1'b0, l == 0, 0, 0);
    endtask

    task automatic active(input int w, input int h, input int hb, input int bad_line, input int bad_w);
        int lw;
        for (int l = 0; l < h; l++) begin
            lw = (l == bad_line) ? bad_w : w;
            for (int c = 0; c < w + hb; c++)
                dclk_cycle(c < lw, 1'b0, c, l);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_pix_valid"},    pix_valid, 0);
        check({tag, "_pix_data"},     pix_data, 0);
        check({tag, "_pix_xy"},       {pix_x, pix_y}, 0);
        check({tag, "_sof_eol_err"},  {sof, eol, timing_err}, 0);
        check({tag, "_frame_width"},  frame_width, 0);
        check({tag, "_frame_height"}, frame_height, 0);
        check({tag, "_frame_count"},  frame_count, 0);
        check({tag, "_locked"},       locked, 0);
    endtask

    initial begin
        #1200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        lcd_dclk = 1'b0; lcd_de = 1'b0; lcd_hsync = 1'b1; lcd_vsync = 1'b0;
        lcd_red = '0; lcd_green = '0; lcd_blue = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        rst_n = 1'b1;
        idle(4);

        // lock after the second frame end
        vblank(3, 69);
        active(64, 32, 5, -1, 0);
        vblank(3, 69);
        check("lock_locked", locked, 1);
        check("lock_width", frame_width, 64);
        check("lock_height", frame_height, 32);
        check("lock_count", frame_count, 0);

        // full locked frame
        pix_cnt = 0; sof_cnt = 0; eol_cnt = 0;
        active(64, 32, 5, -1, 0);
        vblank(3, 69);
        check("frame_pixels", pix_cnt, 2048);
        check("frame_sof", sof_cnt, 1);
        check("frame_eol", eol_cnt, 32);
        check("frame_last_x", last_x, 63);
        check("frame_last_y", last_y, 31);
        check("frame_count_1", frame_count, 1);
        check("frame_locked", locked, 1);
        check("frame_no_err", terr_cnt, 0);

        // one 63-pixel line breaks lock; the next clean frame restores it
        active(64, 32, 5, 10, 63);
        vblank(3, 69);
        check("short_err", terr_cnt, 1);
        check("short_unlocked", locked, 0);
        check("short_count", frame_count, 1);
        active(64, 32, 5, -1, 0);
        vblank(3, 69);
        check("relock_locked", locked, 1);
        check("relock_width", frame_width, 64);
        check("relock_height", frame_height, 32);
        check("relock_no_err", terr_cnt, 1);

        // reset in the middle of a line
        active(64, 5, 5, -1, 0);
        for (int c = 0; c < 10; c++) dclk_cycle(1'b1, 1'b0, c, 5);
        @(negedge clk);
        check("pre_reset_drained", sb.size(), 0);
        exp_active = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("mid");
        rst_n = 1'b1;
        pix_cnt = 0;
        for (int c = 10; c < 69; c++) dclk_cycle(c < 64, 1'b0, c, 5);
        active(64, 2, 5, -1, 0);
        check("post_reset_no_pix", pix_cnt, 0);
        check("post_reset_unlocked", locked, 0);
        vblank(1, 10);
        active(8, 4, 2, -1, 0);
        vblank(1, 10);
        check("small_locked", locked, 1);
        check("small_width", frame_width, 8);
        check("small_height", frame_height, 4);

        // vsync held off for 600 lines: y saturates, lock is lost, then recovered
        pix_cnt = 0;
        active(2, 600, 2, -1, 0);
        vblank(1, 10);
        check("sat_pixels", pix_cnt, 1200);
        check("sat_last_y", last_y, 511);
        check("sat_err", terr_cnt, 2);
        check("sat_unlocked", locked, 0);
        active(8, 4, 2, -1, 0);
        vblank(1, 10);
        check("recover_locked", locked, 1);
        check("recover_width", frame_width, 8);
        check("recover_height", frame_height, 4);

        repeat (10) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
